// File: rtl/pwm_preconditioner_sequencer.sv
// pwm_preconditioner_sequencer: loads DUTY/PHASE arrays from a read-latency
// memory, waits two PRE_DONE pulses, then strobes UPDATE on the next SYNC.
// Ports: CLK, RST_N (async low), START, BUSY, MEM_ADDR/MEM_DUTY/MEM_PHASE,
//   CYCLE, DUTY, PHASE, PRE_DONE, SYNC, UPDATE.
// Option: define PWM_SEQ_DUTY_CLAMP_EN to clamp duty to CYCLE[i] and
//   wrap phase by CYCLE[i] while loading.
module pwm_preconditioner_sequencer #(
  parameter int WIDTH       = 13,
  parameter int DEPTH       = 249,
  parameter int MEM_LATENCY = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   START,
  output logic                   BUSY,
  output logic [7:0]             MEM_ADDR,
  input  logic [WIDTH-1:0]       MEM_DUTY,
  input  logic [WIDTH-1:0]       MEM_PHASE,
  input  logic [WIDTH*DEPTH-1:0] CYCLE,
  output logic [WIDTH*DEPTH-1:0] DUTY,
  output logic [WIDTH*DEPTH-1:0] PHASE,
  input  logic                   PRE_DONE,
  input  logic                   SYNC,
  output logic                   UPDATE
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_CAPTURE,
    WAIT_CALC,
    WAIT_SYNC
  } state_t;

  localparam logic [7:0] LAST = 8'(DEPTH - 1);

  state_t state, state_nxt;

  logic                   pend;
  logic                   rd_act;
  logic                   issue;
  logic                   load_go;
  logic                   load_end;
  logic                   sync_hit;
  logic [MEM_LATENCY-1:0] vld_q;
  logic [7:0]             idx_q [MEM_LATENCY];
  logic                   wr_en;
  logic [7:0]             wr_idx;
  logic [WIDTH-1:0]       wr_duty;
  logic [WIDTH-1:0]       wr_phase;

  assign issue    = (state == LOAD) && rd_act;
  assign wr_en    = vld_q[MEM_LATENCY-1];
  assign wr_idx   = idx_q[MEM_LATENCY-1];
  assign load_end = wr_en && (wr_idx == LAST);
  assign BUSY     = (state != IDLE) || UPDATE;

  always_comb begin
    state_nxt = state;
    load_go   = 1'b0;
    sync_hit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (START || pend) begin
          state_nxt = LOAD;
          load_go   = 1'b1;
        end
      end
      LOAD: begin
        if (load_end) state_nxt = WAIT_CAPTURE;
      end
      // First DONE closes a pass that may have used stale arrays.
      WAIT_CAPTURE: begin
        if (PRE_DONE) state_nxt = WAIT_CALC;
      end
      WAIT_CALC: begin
        if (PRE_DONE) state_nxt = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        if (SYNC) begin
          state_nxt = IDLE;
          sync_hit  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // UPDATE cycle is spent in IDLE, so a pending request
  // relaunches LOAD straight after it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      UPDATE   <= 1'b0;
      pend     <= 1'b0;
      rd_act   <= 1'b0;
      MEM_ADDR <= '0;
    end else begin
      UPDATE <= sync_hit;
      if (state == IDLE) pend <= 1'b0;
      else if (START)    pend <= 1'b1;
      if (load_go) begin
        MEM_ADDR <= '0;
        rd_act   <= 1'b1;
      end else if (issue) begin
        if (MEM_ADDR == LAST) rd_act <= 1'b0;
        else                  MEM_ADDR <= MEM_ADDR + 8'd1;
      end
    end
  end

  // Address/valid delay line matching the memory read latency.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_q <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= issue;
      idx_q[0] <= MEM_ADDR;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

`ifdef PWM_SEQ_DUTY_CLAMP_EN
  logic [WIDTH-1:0] cyc_sel;

  always_comb begin
    cyc_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_idx == 8'(i)) cyc_sel = CYCLE[i*WIDTH +: WIDTH];
    end
  end

  // Phase input is below 2*CYCLE, so one subtract suffices.
  always_comb begin
    wr_duty  = (MEM_DUTY > cyc_sel) ? cyc_sel : MEM_DUTY;
    wr_phase = (MEM_PHASE >= cyc_sel) ? MEM_PHASE - cyc_sel
                                      : MEM_PHASE;
  end
`else
  logic cycle_unused;

  assign cycle_unused = ^CYCLE;
  assign wr_duty      = MEM_DUTY;
  assign wr_phase     = MEM_PHASE;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DUTY  <= '0;
      PHASE <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (wr_idx == 8'(i))) begin
          DUTY[i*WIDTH +: WIDTH]  <= wr_duty;
          PHASE[i*WIDTH +: WIDTH] <= wr_phase;
        end
      end
    end
  end

endmodule
